// File: rtl/serial_add4_if.sv
// Operand/result bundle for the four-operand bit-serial adder.
// Latency: n/a (wires only); ovf exists only when SERIALADD_OVF_EN is defined.
// Backpressure: none; master drives start/operands, slave returns q/q_valid.
interface serial_add4_if #(
  parameter int LEN = 10
);
  logic           start;
  logic [LEN-1:0] a1;
  logic [LEN-1:0] a2;
  logic [LEN-1:0] a3;
  logic [LEN-1:0] a4;
  logic [LEN-1:0] q;
  logic           q_valid;
`ifdef SERIALADD_OVF_EN
  logic           ovf;
`endif

`ifdef SERIALADD_OVF_EN
  modport master (output start, a1, a2, a3, a4, input q, q_valid, ovf);
  modport slave  (input start, a1, a2, a3, a4, output q, q_valid, ovf);
`else
  modport master (output start, a1, a2, a3, a4, input q, q_valid);
  modport slave  (input start, a1, a2, a3, a4, output q, q_valid);
`endif
endinterface

// File: rtl/serial_add4.sv
// Four-operand bit-serial adder: 4x PISO -> serial 4-input adder -> SIPO (macro SERIALADD_OVF_EN adds ovf).
// Latency: q/q_valid update LEN+1 cycles after the edge sampling start.
// Backpressure: none; a start mid-frame aborts the frame in flight.
module serial_add4 #(
  parameter int LEN = 10
) (
  input logic         clk,
  input logic         reset,
  serial_add4_if.slave bus
);

  localparam int CW = (LEN > 2) ? $clog2(LEN) : 1;

  // PISO stage
  logic [LEN-1:0] sh1, sh2, sh3, sh4;
  logic           piso_sync;

  // Serial adder stage
  logic [1:0]     carry;
  logic [1:0]     carry_in;
  logic [2:0]     sum_s;
  logic           add_bit;
  logic           add_sync;

  // SIPO stage
  logic [LEN-1:0] word;
  logic [CW-1:0]  cnt;
  logic           active;
  logic [LEN-1:0] q_r;
  logic           q_valid_r;
`ifdef SERIALADD_OVF_EN
  logic           ovf_r;
`endif

  // Load operands on start, otherwise shift right feeding zeros; sync marks bit 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sh1       <= '0;
      sh2       <= '0;
      sh3       <= '0;
      sh4       <= '0;
      piso_sync <= 1'b0;
    end else if (bus.start) begin
      sh1       <= bus.a1;
      sh2       <= bus.a2;
      sh3       <= bus.a3;
      sh4       <= bus.a4;
      piso_sync <= 1'b1;
    end else begin
      sh1       <= sh1 >> 1;
      sh2       <= sh2 >> 1;
      sh3       <= sh3 >> 1;
      sh4       <= sh4 >> 1;
      piso_sync <= 1'b0;
    end
  end

  // Column sum of the four serial bits plus carry; carry ignored on a word's LSB.
  always_comb begin
    carry_in = piso_sync ? 2'b00 : carry;
    sum_s    = {2'b00, sh1[0]} + {2'b00, sh2[0]} + {2'b00, sh3[0]} + {2'b00, sh4[0]}
             + {1'b0, carry_in};
  end

  // Register the sum bit, the forwarded sync and the 2-bit carry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      add_bit  <= 1'b0;
      add_sync <= 1'b0;
      carry    <= 2'b00;
    end else begin
      add_bit  <= sum_s[0];
      add_sync <= piso_sync;
      carry    <= sum_s[2:1];
    end
  end

  // Deserialise; sync restarts the word, the last bit publishes q for one cycle.
  // During the cycle the last bit is captured, carry still holds the frame's final carry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      word      <= '0;
      cnt       <= '0;
      active    <= 1'b0;
      q_r       <= '0;
      q_valid_r <= 1'b0;
`ifdef SERIALADD_OVF_EN
      ovf_r     <= 1'b0;
`endif
    end else begin
      q_valid_r <= 1'b0;
      if (add_sync) begin
        word[0] <= add_bit;
        cnt     <= CW'(1);
        active  <= 1'b1;
      end else if (active) begin
        word[cnt] <= add_bit;
        if (cnt == CW'(LEN - 1)) begin
          q_r       <= {add_bit, word[LEN-2:0]};
          q_valid_r <= 1'b1;
          active    <= 1'b0;
`ifdef SERIALADD_OVF_EN
          ovf_r     <= |carry;
`endif
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign bus.q       = q_r;
  assign bus.q_valid = q_valid_r;
`ifdef SERIALADD_OVF_EN
  assign bus.ovf     = ovf_r;
`endif

endmodule

// File: tb/tb_serial_add4.sv
// Directed bench for serial_add4 with LEN=10 (ovf checks only with SERIALADD_OVF_EN).
// Latency: expects q_valid 11 cycles after the start edge.
// Backpressure: none; stimulus driven on falling edges, outputs sampled on falling edges.
module tb_serial_add4;
  localparam int LEN = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  serial_add4_if #(.LEN(LEN)) bus ();

  serial_add4 #(.LEN(LEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Pulse start for one edge, then scramble operands so late sampling shows up.
  task automatic apply_start(input logic [LEN-1:0] v1, v2, v3, v4);
    bus.a1 = v1; bus.a2 = v2; bus.a3 = v3; bus.a4 = v4;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a1 = 10'h155; bus.a2 = 10'h2aa; bus.a3 = 10'h3ff; bus.a4 = 10'h0f0;
  endtask

  // Wait for q_valid; lat = falling edges since the start edge, 99 on timeout.
  task automatic wait_valid(output int lat);
    lat = 99;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.q_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0;
    bus.a1 = '0; bus.a2 = '0; bus.a3 = '0; bus.a4 = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (bus.q !== 10'h000) begin err_cnt++; $display("FAIL reset_q got %h want 000", bus.q); end
    vec_cnt++;
    if (bus.q_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_qv got %b want 0", bus.q_valid); end
`ifdef SERIALADD_OVF_EN
    vec_cnt++;
    if (bus.ovf !== 1'b0) begin err_cnt++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
`endif
    // start while in reset must be ignored
    bus.a1 = 10'd1; bus.a2 = 10'd1; bus.a3 = 10'd1; bus.a4 = 10'd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    reset = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (15) begin
        @(negedge clk);
        if (bus.q_valid) seen++;
      end
      vec_cnt++;
      if (seen != 0) begin err_cnt++; $display("FAIL start_in_reset q_valid pulses got %0d want 0", seen); end
    end
  endtask

  task automatic test_basic;
    int lat;
    apply_start(10'd1, 10'd2, 10'd3, 10'd4);
    wait_valid(lat);
    vec_cnt++;
    if (lat != 11) begin err_cnt++; $display("FAIL basic_latency got %0d want 11", lat); end
    vec_cnt++;
    if (bus.q !== 10'h00a) begin err_cnt++; $display("FAIL basic_q got %h want 00a", bus.q); end
`ifdef SERIALADD_OVF_EN
    vec_cnt++;
    if (bus.ovf !== 1'b0) begin err_cnt++; $display("FAIL basic_ovf got %b want 0", bus.ovf); end
`endif
    @(negedge clk);
    vec_cnt++;
    if (bus.q_valid !== 1'b0) begin err_cnt++; $display("FAIL basic_pulse_width q_valid got %b want 0", bus.q_valid); end
    repeat (5) @(negedge clk);
    vec_cnt++;
    if (bus.q !== 10'h00a) begin err_cnt++; $display("FAIL basic_hold got %h want 00a", bus.q); end
  endtask

  task automatic test_increment;
    logic [LEN-1:0] exp_q [10] = '{10'h00a, 10'h00e, 10'h012, 10'h016, 10'h01a,
                                   10'h01e, 10'h022, 10'h026, 10'h02a, 10'h02e};
    int lat;
    for (int n = 0; n < 10; n++) begin
      apply_start(LEN'(1 + n), LEN'(2 + n), LEN'(3 + n), LEN'(4 + n));
      wait_valid(lat);
      vec_cnt++;
      if (lat != 11 || bus.q !== exp_q[n]) begin
        err_cnt++;
        $display("FAIL incr_frame%0d got q=%h lat=%0d want q=%h lat=11", n, bus.q, lat, exp_q[n]);
      end
      if (lat < 31) repeat (31 - lat) @(negedge clk);
    end
  endtask

  task automatic test_wrap;
    int lat;
    apply_start(10'h3ff, 10'h3ff, 10'h3ff, 10'h3ff);
    wait_valid(lat);
    vec_cnt++;
    if (bus.q !== 10'h3fc) begin err_cnt++; $display("FAIL wrap_max_q got %h want 3fc", bus.q); end
`ifdef SERIALADD_OVF_EN
    vec_cnt++;
    if (bus.ovf !== 1'b1) begin err_cnt++; $display("FAIL wrap_max_ovf got %b want 1", bus.ovf); end
`endif
    repeat (3) @(negedge clk);
    apply_start(10'h000, 10'h000, 10'h000, 10'h000);
    wait_valid(lat);
    vec_cnt++;
    if (lat != 11 || bus.q !== 10'h000) begin
      err_cnt++; $display("FAIL wrap_zero got q=%h lat=%0d want q=000 lat=11", bus.q, lat);
    end
`ifdef SERIALADD_OVF_EN
    vec_cnt++;
    if (bus.ovf !== 1'b0) begin err_cnt++; $display("FAIL wrap_zero_ovf got %b want 0", bus.ovf); end
`endif
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int t;
    int nv;
    apply_start(10'd1, 10'd1, 10'd1, 10'd1);
    repeat (9) @(negedge clk);
    apply_start(10'h100, 10'h100, 10'h100, 10'h100);
    t = 10;
    nv = 0;
    repeat (30) begin
      @(negedge clk);
      t++;
      if (bus.q_valid) begin
        nv++;
        if (nv == 1) begin
          vec_cnt++;
          if (t != 11 || bus.q !== 10'h004) begin
            err_cnt++; $display("FAIL b2b_first got q=%h t=%0d want q=004 t=11", bus.q, t);
          end
        end else if (nv == 2) begin
          vec_cnt++;
          if (t != 21 || bus.q !== 10'h000) begin
            err_cnt++; $display("FAIL b2b_second got q=%h t=%0d want q=000 t=21", bus.q, t);
          end
`ifdef SERIALADD_OVF_EN
          vec_cnt++;
          if (bus.ovf !== 1'b1) begin err_cnt++; $display("FAIL b2b_second_ovf got %b want 1", bus.ovf); end
`endif
        end
      end
    end
    vec_cnt++;
    if (nv != 2) begin err_cnt++; $display("FAIL b2b_count got %0d want 2", nv); end
  endtask

  task automatic test_abort;
    int t;
    int first_t;
    int nv;
    apply_start(10'd7, 10'd9, 10'd11, 10'd13);
    repeat (3) @(negedge clk);
    apply_start(10'd5, 10'd5, 10'd5, 10'd5);
    t = 0;
    nv = 0;
    first_t = -1;
    repeat (30) begin
      @(negedge clk);
      t++;
      if (bus.q_valid) begin
        nv++;
        if (nv == 1) begin
          first_t = t;
          vec_cnt++;
          if (bus.q !== 10'h014) begin err_cnt++; $display("FAIL abort_q got %h want 014", bus.q); end
        end
      end
    end
    vec_cnt++;
    if (nv != 1 || first_t != 11) begin
      err_cnt++; $display("FAIL abort_valid got count=%0d t=%0d want count=1 t=11", nv, first_t);
    end
  endtask

  task automatic test_reset_midframe;
    int t;
    int first_t;
    int nv;
    apply_start(10'd1, 10'd2, 10'd3, 10'd4);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (bus.q !== 10'h000 || bus.q_valid !== 1'b0) begin
      err_cnt++; $display("FAIL midreset_clear got q=%h qv=%b want q=000 qv=0", bus.q, bus.q_valid);
    end
    // first start in the very first cycle out of reset
    reset = 1'b1;
    apply_start(10'd1, 10'd2, 10'd3, 10'd4);
    t = 0;
    nv = 0;
    first_t = -1;
    repeat (25) begin
      @(negedge clk);
      t++;
      if (bus.q_valid) begin
        nv++;
        if (nv == 1) begin
          first_t = t;
          vec_cnt++;
          if (bus.q !== 10'h00a) begin err_cnt++; $display("FAIL midreset_restart_q got %h want 00a", bus.q); end
        end
      end
    end
    vec_cnt++;
    if (nv != 1 || first_t != 11) begin
      err_cnt++; $display("FAIL midreset_valid got count=%0d t=%0d want count=1 t=11", nv, first_t);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_increment();
    test_wrap();
    test_back_to_back();
    repeat (15) @(negedge clk);
    test_abort();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
